// File: rtl/alu_operand_issue.sv
// Operand issue and writeback stage feeding the ALU.
// It holds a 32-entry register file, streams operands and watches for ALU timeouts.
module alu_operand_issue #(
    parameter int BUS_WIDTH      = 32,
    parameter int OPCODE_WIDTH   = 11,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    dec_valid,
    output logic                    dec_ready,
    input  logic [OPCODE_WIDTH-1:0] dec_op_code,
    input  logic [4:0]              dec_rs1,
    input  logic [4:0]              dec_rs2,
    input  logic [4:0]              dec_rd,
    input  logic                    dec_use_imme,
    input  logic [BUS_WIDTH-1:0]    dec_imme_value,
    input  logic                    rf_init_we,
    input  logic [4:0]              rf_init_addr,
    input  logic [BUS_WIDTH-1:0]    rf_init_data,
    output logic [BUS_WIDTH-1:0]    imme_value,
    output logic [BUS_WIDTH-1:0]    rs_data,
    output logic                    rs_data_sel,
    output logic                    rs_data_valid,
    output logic [OPCODE_WIDTH-1:0] op_code,
    input  logic [BUS_WIDTH-1:0]    alu_out,
    input  logic                    alu_valid_out,
    input  logic                    op_done,
    output logic                    retire_valid,
    output logic [4:0]              retire_rd,
    output logic [BUS_WIDTH-1:0]    retire_data,
    output logic                    timeout_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] WD_MAX = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND_RS1,
        SEND_RS2,
        WAIT_DONE
    } state_t;

    state_t               state;
    logic [BUS_WIDTH-1:0] rf [32];
    logic [4:0]           rs2_q;
    logic [4:0]           rd_q;
    logic                 use_imme_q;
    logic                 got_result;
    logic [CW-1:0]        wdog;
    logic [BUS_WIDTH-1:0] rs1_val;
    logic [BUS_WIDTH-1:0] rs2_val;

    // rs1 is read at accept time, so a preload in the same cycle is forwarded
    always_comb begin
        rs1_val = rf[dec_rs1];
        if (rf_init_we && rf_init_addr == dec_rs1) rs1_val = rf_init_data;
        if (dec_rs1 == 5'd0) rs1_val = '0;
        rs2_val = (rs2_q == 5'd0) ? '0 : rf[rs2_q];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            dec_ready     <= 1'b0;
            imme_value    <= '0;
            rs_data       <= '0;
            rs_data_sel   <= 1'b0;
            rs_data_valid <= 1'b0;
            op_code       <= '0;
            retire_valid  <= 1'b0;
            retire_rd     <= '0;
            retire_data   <= '0;
            timeout_err   <= 1'b0;
            rs2_q         <= '0;
            rd_q          <= '0;
            use_imme_q    <= 1'b0;
            got_result    <= 1'b0;
            wdog          <= '0;
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else begin
            retire_valid <= 1'b0;
            timeout_err  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rf_init_we && rf_init_addr != 5'd0)
                        rf[rf_init_addr] <= rf_init_data;
                    if (dec_valid && dec_ready) begin
                        op_code       <= dec_op_code;
                        imme_value    <= dec_imme_value;
                        rs2_q         <= dec_rs2;
                        rd_q          <= dec_rd;
                        use_imme_q    <= dec_use_imme;
                        rs_data       <= rs1_val;
                        rs_data_sel   <= 1'b0;
                        rs_data_valid <= 1'b1;
                        dec_ready     <= 1'b0;
                        state         <= SEND_RS1;
                    end else begin
                        dec_ready <= 1'b1;
                    end
                end
                SEND_RS1: begin
                    if (use_imme_q) begin
                        rs_data_valid <= 1'b0;
                        wdog          <= '0;
                        got_result    <= 1'b0;
                        state         <= WAIT_DONE;
                    end else begin
                        rs_data     <= rs2_val;
                        rs_data_sel <= 1'b1;
                        state       <= SEND_RS2;
                    end
                end
                SEND_RS2: begin
                    rs_data_valid <= 1'b0;
                    rs_data_sel   <= 1'b0;
                    wdog          <= '0;
                    got_result    <= 1'b0;
                    state         <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (alu_valid_out && !got_result) begin
                        if (rd_q != 5'd0) rf[rd_q] <= alu_out;
                        got_result   <= 1'b1;
                        retire_valid <= 1'b1;
                        retire_rd    <= rd_q;
                        retire_data  <= alu_out;
                    end
                    if (op_done) begin
                        dec_ready <= 1'b1;
                        state     <= IDLE;
                    end else if (wdog == WD_MAX) begin
                        timeout_err <= 1'b1;
                        dec_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wdog <= wdog + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue.
// Directed table, hand-written corner sequences and random ops against a reference model.
module tb_alu_operand_issue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [10:0] dec_op_code = '0;
    logic [4:0]  dec_rs1 = '0;
    logic [4:0]  dec_rs2 = '0;
    logic [4:0]  dec_rd = '0;
    logic        dec_use_imme = 1'b0;
    logic [31:0] dec_imme_value = '0;
    logic        rf_init_we = 1'b0;
    logic [4:0]  rf_init_addr = '0;
    logic [31:0] rf_init_data = '0;
    logic [31:0] imme_value;
    logic [31:0] rs_data;
    logic        rs_data_sel;
    logic        rs_data_valid;
    logic [10:0] op_code;
    logic [31:0] alu_out = '0;
    logic        alu_valid_out = 1'b0;
    logic        op_done = 1'b0;
    logic        retire_valid;
    logic [4:0]  retire_rd;
    logic [31:0] retire_data;
    logic        timeout_err;

    alu_operand_issue dut (
        .clk(clk), .rst(rst),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_op_code(dec_op_code), .dec_rs1(dec_rs1),
        .dec_rs2(dec_rs2), .dec_rd(dec_rd),
        .dec_use_imme(dec_use_imme), .dec_imme_value(dec_imme_value),
        .rf_init_we(rf_init_we), .rf_init_addr(rf_init_addr),
        .rf_init_data(rf_init_data),
        .imme_value(imme_value), .rs_data(rs_data),
        .rs_data_sel(rs_data_sel), .rs_data_valid(rs_data_valid),
        .op_code(op_code), .alu_out(alu_out),
        .alu_valid_out(alu_valid_out), .op_done(op_done),
        .retire_valid(retire_valid), .retire_rd(retire_rd),
        .retire_data(retire_data), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        ui;
        logic [31:0] imm;
        logic [10:0] op;
        int          lat;
        bit          split;
        logic [31:0] e1;
        logic [31:0] e2;
    } vec_t;

    vec_t        tbl [8];
    logic [31:0] ref_rf [32];
    int          total = 0;
    int          passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] alu_fn(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op[1:0])
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: return a ^ b;
            default: return b;
        endcase
    endfunction

    task automatic preload(input logic [4:0] a, input logic [31:0] d);
        rf_init_we = 1'b1;
        rf_init_addr = a;
        rf_init_data = d;
        if (a != 5'd0) ref_rf[a] = d;
        step();
        rf_init_we = 1'b0;
    endtask

    task automatic issue(input vec_t v);
        logic [31:0] res;
        int          n;
        bit          seen_ret;
        res = alu_fn(v.op, v.e1, v.ui ? v.imm : v.e2);
        chk("ready", 32'(dec_ready), 32'd1);
        dec_valid = 1'b1;
        dec_rs1 = v.rs1;
        dec_rs2 = v.rs2;
        dec_rd = v.rd;
        dec_use_imme = v.ui;
        dec_imme_value = v.imm;
        dec_op_code = v.op;
        step();
        dec_valid = 1'b0;
        rf_init_we = 1'b0;
        chk("b1_valid", 32'(rs_data_valid), 32'd1);
        chk("b1_sel", 32'(rs_data_sel), 32'd0);
        chk("b1_data", rs_data, v.e1);
        chk("b1_busy", 32'(dec_ready), 32'd0);
        chk("opcode", 32'(op_code), 32'(v.op));
        step();
        if (!v.ui) begin
            chk("b2_valid", 32'(rs_data_valid), 32'd1);
            chk("b2_sel", 32'(rs_data_sel), 32'd1);
            chk("b2_data", rs_data, v.e2);
            step();
        end
        chk("nobeat", 32'(rs_data_valid), 32'd0);
        chk("w_sel", 32'(rs_data_sel), 32'd0);
        chk("imme", imme_value, v.imm);
        if (v.lat < 0) begin
            rf_init_we = 1'b1;
            rf_init_addr = v.rs1;
            rf_init_data = 32'hBAD;
            n = 0;
            seen_ret = 1'b0;
            while (!timeout_err && n < 200) begin
                step();
                n++;
                if (retire_valid) seen_ret = 1'b1;
            end
            rf_init_we = 1'b0;
            chk("to_lat", 32'(n), 32'd64);
            chk("to_noret", 32'(seen_ret), 32'd0);
            chk("to_ready", 32'(dec_ready), 32'd1);
            step();
            chk("to_pulse", 32'(timeout_err), 32'd0);
            return;
        end
        for (int i = 0; i < v.lat; i++) step();
        alu_valid_out = 1'b1;
        alu_out = res;
        op_done = !v.split;
        step();
        alu_valid_out = 1'b0;
        op_done = 1'b0;
        chk("ret_valid", 32'(retire_valid), 32'd1);
        chk("ret_rd", 32'(retire_rd), 32'(v.rd));
        chk("ret_data", retire_data, res);
        if (v.split) begin
            chk("split_busy", 32'(dec_ready), 32'd0);
            alu_valid_out = 1'b1;
            alu_out = ~res;
            op_done = 1'b1;
            step();
            alu_valid_out = 1'b0;
            op_done = 1'b0;
            chk("spur_ret", 32'(retire_valid), 32'd0);
        end
        chk("done_ready", 32'(dec_ready), 32'd1);
        if (v.rd != 5'd0) ref_rf[v.rd] = res;
    endtask

    initial begin
        vec_t v;
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        tbl[0] = '{5'd1, 5'd2, 5'd3, 1'b0, 32'h0,    11'd0, 0, 1'b0, 32'd5,    32'd7};
        tbl[1] = '{5'd1, 5'd0, 5'd5, 1'b1, 32'h10,   11'd0, 2, 1'b0, 32'd5,    32'd0};
        tbl[2] = '{5'd0, 5'd0, 5'd0, 1'b1, 32'hDEAD, 11'd3, 1, 1'b0, 32'd0,    32'd0};
        tbl[3] = '{5'd0, 5'd3, 5'd6, 1'b0, 32'h0,    11'd0, 0, 1'b0, 32'd0,    32'd12};
        tbl[4] = '{5'd5, 5'd3, 5'd4, 1'b0, 32'h0,    11'd1, 0, 1'b0, 32'h15,   32'd12};
        tbl[5] = '{5'd4, 5'd0, 5'd7, 1'b1, 32'h1,    11'd0, 3, 1'b0, 32'd9,    32'd0};
        tbl[6] = '{5'd2, 5'd7, 5'd8, 1'b0, 32'h0,    11'd2, 1, 1'b1, 32'd7,    32'd10};
        tbl[7] = '{5'd8, 5'd1, 5'd9, 1'b0, 32'h0,    11'd0, 0, 1'b0, 32'd13,   32'd5};

        step();
        step();
        chk("rst_ready", 32'(dec_ready), 32'd0);
        chk("rst_valid", 32'(rs_data_valid), 32'd0);
        chk("rst_data", rs_data, 32'd0);
        chk("rst_ret", 32'(retire_valid), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        rst = 1'b0;
        step();
        chk("rst_ready1", 32'(dec_ready), 32'd1);

        preload(5'd1, 32'd5);
        preload(5'd2, 32'd7);
        for (int i = 0; i < 8; i++) issue(tbl[i]);

        v = '{5'd1, 5'd2, 5'd12, 1'b0, 32'h0, 11'd0, -1, 1'b0, 32'd5, 32'd7};
        issue(v);
        v = '{5'd1, 5'd0, 5'd2, 1'b1, 32'h0, 11'd0, 0, 1'b0, 32'd5, 32'd0};
        issue(v);

        rf_init_we = 1'b1;
        rf_init_addr = 5'd10;
        rf_init_data = 32'h55;
        ref_rf[10] = 32'h55;
        v = '{5'd10, 5'd0, 5'd11, 1'b1, 32'h2, 11'd0, 0, 1'b0, 32'h55, 32'd0};
        issue(v);

        dec_valid = 1'b1;
        dec_rs1 = 5'd1;
        dec_rs2 = 5'd2;
        dec_rd = 5'd3;
        dec_use_imme = 1'b0;
        dec_imme_value = 32'h77;
        dec_op_code = 11'd2;
        step();
        dec_valid = 1'b0;
        step();
        chk("mr_sel", 32'(rs_data_sel), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mr_valid", 32'(rs_data_valid), 32'd0);
        chk("mr_sel0", 32'(rs_data_sel), 32'd0);
        chk("mr_data", rs_data, 32'd0);
        chk("mr_imm", imme_value, 32'd0);
        chk("mr_op", 32'(op_code), 32'd0);
        chk("mr_ret", 32'(retire_valid), 32'd0);
        chk("mr_rdata", retire_data, 32'd0);
        chk("mr_ready0", 32'(dec_ready), 32'd0);
        step();
        for (int i = 0; i < 32; i++) ref_rf[i] = '0;
        v = '{5'd1, 5'd2, 5'd1, 1'b0, 32'h0, 11'd0, 0, 1'b0, 32'd0, 32'd0};
        issue(v);

        for (int k = 0; k < 32; k++) preload(5'(k), $urandom);
        for (int k = 0; k < 40; k++) begin
            if ($urandom_range(0, 3) == 0)
                preload(5'($urandom_range(0, 31)), $urandom);
            v.rs1 = 5'($urandom_range(0, 31));
            v.rs2 = 5'($urandom_range(0, 31));
            v.rd = 5'($urandom_range(0, 31));
            v.ui = 1'($urandom_range(0, 1));
            v.imm = $urandom;
            v.op = 11'($urandom_range(0, 3));
            v.lat = int'($urandom_range(0, 4));
            v.split = ($urandom_range(0, 3) == 0);
            v.e1 = ref_rf[v.rs1];
            v.e2 = ref_rf[v.rs2];
            issue(v);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
